// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: MIPS decode stage with register file, load-use stall and branch prediction.
// Latency: one cycle from i_instruction to the ID/EX outputs; o_stall, o_branch_prediction and
//          o_branch_target_addr are combinational.
// Backpressure: o_stall holds IF on a load-use hazard and inserts a bubble; i_flush overrides all.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_valid/i_pc/i_next_pc/
//   i_instruction              instruction presented by IF
//   i_reg_write/i_write_*      WB write port (write-through bypassed into same-cycle reads)
//   i_ex_mem_read/i_ex_rt      load currently in EX, used for load-use detection
//   i_flush                    mispredict flush from EX
//   i_bht_*                    resolved branch outcome for the predictor
//   o_stall, o_branch_*        combinational feedback to IF
//   o_*                        registered ID/EX pipeline register
//
// Optional feature macro: ID_BHT_EN
//   defined   : 2-bit saturating branch history table indexed by PC[$clog2(BHT_ENTRIES)+1:2]
//   undefined : no BHT storage; static backward-taken prediction from imm[15]

module id_stage_pipelined #(
   parameter  int DATA_W      = 32,
   parameter  int NUM_REGS    = 32,
   parameter  int BHT_ENTRIES = 16,
   localparam int RA_W        = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [31:0]       i_pc,
   input  logic [31:0]       i_next_pc,
   input  logic [31:0]       i_instruction,
   input  logic              i_reg_write,
   input  logic [RA_W-1:0]   i_write_register,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic              i_ex_mem_read,
   input  logic [RA_W-1:0]   i_ex_rt,
   input  logic              i_flush,
   input  logic              i_bht_update,
   input  logic [31:0]       i_bht_pc,
   input  logic              i_bht_taken,
   output logic              o_stall,
   output logic              o_branch_prediction,
   output logic [31:0]       o_branch_target_addr,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_read_data_1,
   output logic [DATA_W-1:0] o_read_data_2,
   output logic [DATA_W-1:0] o_sign_extended_imm,
   output logic [RA_W-1:0]   o_rs,
   output logic [RA_W-1:0]   o_rt,
   output logic [RA_W-1:0]   o_rd,
   output logic [5:0]        o_opcode,
   output logic [5:0]        o_function,
   output logic              o_alu_src,
   output logic              o_reg_dst,
   output logic              o_reg_write,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_mem_to_reg,
   output logic              o_branch,
   output logic [1:0]        o_alu_op,
   output logic              o_pred_taken
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef struct packed {
      logic       alu_src;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   // ------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [15:0]       imm16;
   logic [RA_W-1:0]   rs;
   logic [RA_W-1:0]   rt;
   logic [RA_W-1:0]   rd;
   logic [DATA_W-1:0] imm_ext;
   logic [31:0]       imm_ext32;

   assign opcode    = i_instruction[31:26];
   assign funct     = i_instruction[5:0];
   assign imm16     = i_instruction[15:0];
   assign rs        = i_instruction[21 +: RA_W];
   assign rt        = i_instruction[16 +: RA_W];
   assign rd        = i_instruction[11 +: RA_W];
   assign imm_ext   = {{(DATA_W-16){imm16[15]}}, imm16};
   assign imm_ext32 = {{16{imm16[15]}}, imm16};

   // Target is formed for every instruction; IF only uses it when a branch is predicted taken.
   assign o_branch_target_addr = i_next_pc + {imm_ext32[29:0], 2'b00};

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   ctrl_t ctrl;
   logic  rt_is_src;
   logic  is_branch;

   always_comb begin
      ctrl      = '0;
      rt_is_src = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = 2'b10;
            rt_is_src      = 1'b1;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            rt_is_src      = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = 2'b01;
            rt_is_src   = 1'b1;
            is_branch   = 1'b1;
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Register file with write-through bypass
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic              wr_en;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   // Index range guard keeps non-power-of-two register counts safe.
   assign wr_en = i_reg_write && (i_write_register != '0) &&
                  ({1'b0, i_write_register} < (RA_W+1)'(NUM_REGS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         rf_q[i_write_register] <= i_write_data;
      end
   end

   always_comb begin
      rd1 = '0;
      if (rs != '0 && ({1'b0, rs} < (RA_W+1)'(NUM_REGS))) begin
         rd1 = (wr_en && i_write_register == rs) ? i_write_data : rf_q[rs];
      end
   end

   always_comb begin
      rd2 = '0;
      if (rt != '0 && ({1'b0, rt} < (RA_W+1)'(NUM_REGS))) begin
         rd2 = (wr_en && i_write_register == rt) ? i_write_data : rf_q[rt];
      end
   end

   // ------------------------------------------------------------------
   // Load-use hazard; a flush kills the instruction so there is nothing to stall
   // ------------------------------------------------------------------
   logic hazard;

   assign hazard  = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == rs) || (rt_is_src && (i_ex_rt == rt)));
   assign o_stall = hazard && !i_flush;

   // ------------------------------------------------------------------
   // Branch prediction
   // ------------------------------------------------------------------
   logic pred_dir;

`ifdef ID_BHT_EN
   localparam int BHT_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [BHT_W-1:0] lookup_idx;
   logic [BHT_W-1:0] update_idx;

   assign lookup_idx = i_pc[BHT_W+1:2];
   assign update_idx = i_bht_pc[BHT_W+1:2];

   // Lookup reads the registered counter, so a same-cycle update is seen only next cycle.
   assign pred_dir = bht_q[lookup_idx][1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (i_bht_update) begin
         if (i_bht_taken) begin
            if (bht_q[update_idx] != 2'b11) bht_q[update_idx] <= bht_q[update_idx] + 2'd1;
         end else begin
            if (bht_q[update_idx] != 2'b00) bht_q[update_idx] <= bht_q[update_idx] - 2'd1;
         end
      end
   end
`else
   // Backward branches (negative offset) are assumed to be loops and predicted taken.
   assign pred_dir = imm16[15];
`endif

   assign o_branch_prediction = i_valid && is_branch && pred_dir && !o_stall && !i_flush;

   // ------------------------------------------------------------------
   // ID/EX pipeline register
   // ------------------------------------------------------------------
   logic              load_en;
   logic              valid_q,  valid_d;
   logic              pred_q,   pred_d;
   ctrl_t             ctrl_q,   ctrl_d;
   logic [DATA_W-1:0] rd1_q,    rd1_d;
   logic [DATA_W-1:0] rd2_q,    rd2_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   logic [RA_W-1:0]   rs_q,     rs_d;
   logic [RA_W-1:0]   rt_q,     rt_d;
   logic [RA_W-1:0]   rd_q,     rd_d;
   logic [5:0]        op_q,     op_d;
   logic [5:0]        fn_q,     fn_d;

   // Flush, stall and invalid input all collapse to the same bubble.
   assign load_en = i_valid && !o_stall && !i_flush;

   always_comb begin
      valid_d = 1'b0;
      pred_d  = 1'b0;
      ctrl_d  = '0;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      op_d    = op_q;
      fn_d    = fn_q;
      if (load_en) begin
         valid_d = 1'b1;
         pred_d  = o_branch_prediction;
         ctrl_d  = ctrl;
         rd1_d   = rd1;
         rd2_d   = rd2;
         imm_d   = imm_ext;
         rs_d    = rs;
         rt_d    = rt;
         rd_d    = rd;
         op_d    = opcode;
         fn_d    = funct;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         pred_q  <= 1'b0;
         ctrl_q  <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         op_q    <= '0;
         fn_q    <= '0;
      end else begin
         valid_q <= valid_d;
         pred_q  <= pred_d;
         ctrl_q  <= ctrl_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         op_q    <= op_d;
         fn_q    <= fn_d;
      end
   end

   assign o_valid             = valid_q;
   assign o_pred_taken        = pred_q;
   assign o_read_data_1       = rd1_q;
   assign o_read_data_2       = rd2_q;
   assign o_sign_extended_imm = imm_q;
   assign o_rs                = rs_q;
   assign o_rt                = rt_q;
   assign o_rd                = rd_q;
   assign o_opcode            = op_q;
   assign o_function          = fn_q;
   assign o_alu_src           = ctrl_q.alu_src;
   assign o_reg_dst           = ctrl_q.reg_dst;
   assign o_reg_write         = ctrl_q.reg_write;
   assign o_mem_read          = ctrl_q.mem_read;
   assign o_mem_write         = ctrl_q.mem_write;
   assign o_mem_to_reg        = ctrl_q.mem_to_reg;
   assign o_branch            = ctrl_q.branch;
   assign o_alu_op            = ctrl_q.alu_op;

   // PC bits outside the BHT index, shamt and (without the BHT) the update port carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{i_pc, i_bht_pc, i_bht_update, i_bht_taken, i_instruction};

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed scenarios followed by random traffic,
// all checked against a behavioural model of decode, register file, hazard and prediction rules.
// Works for both predictor builds (ID_BHT_EN defined or not).

module tb_id_stage_pipelined;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid, i_reg_write, i_ex_mem_read, i_flush, i_bht_update, i_bht_taken;
   logic [31:0] i_pc, i_next_pc, i_instruction, i_bht_pc, i_write_data;
   logic [4:0]  i_write_register, i_ex_rt;

   logic        o_stall, o_branch_prediction, o_valid, o_pred_taken;
   logic [31:0] o_branch_target_addr, o_read_data_1, o_read_data_2, o_sign_extended_imm;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [5:0]  o_opcode, o_function;
   logic        o_alu_src, o_reg_dst, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch;
   logic [1:0]  o_alu_op;

   always #5 clk = ~clk;

   id_stage_pipelined dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_pc(i_pc), .i_next_pc(i_next_pc), .i_instruction(i_instruction),
      .i_reg_write(i_reg_write), .i_write_register(i_write_register), .i_write_data(i_write_data),
      .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_flush(i_flush),
      .i_bht_update(i_bht_update), .i_bht_pc(i_bht_pc), .i_bht_taken(i_bht_taken),
      .o_stall(o_stall), .o_branch_prediction(o_branch_prediction),
      .o_branch_target_addr(o_branch_target_addr), .o_valid(o_valid),
      .o_read_data_1(o_read_data_1), .o_read_data_2(o_read_data_2),
      .o_sign_extended_imm(o_sign_extended_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
      .o_opcode(o_opcode), .o_function(o_function), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
      .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_mem_to_reg(o_mem_to_reg), .o_branch(o_branch), .o_alu_op(o_alu_op),
      .o_pred_taken(o_pred_taken)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_rf  [32];
   logic [1:0]  m_bht [16];
   logic        e_valid, e_pred;
   logic [8:0]  e_ctrl;
   logic [31:0] e_rd1, e_rd2, e_imm;
   logic [4:0]  e_rs, e_rt, e_rd;
   logic [5:0]  e_op, e_fn;

   // {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, alu_op}
   function automatic logic [8:0] m_ctrl(input logic [5:0] op);
      case (op)
         6'h00:        return 9'b0_1_1_0_0_0_0_10;
         6'h23:        return 9'b1_0_1_1_0_1_0_00;
         6'h2B:        return 9'b1_0_0_0_1_0_0_00;
         6'h04, 6'h05: return 9'b0_0_0_0_0_0_1_01;
         6'h08:        return 9'b1_0_1_0_0_0_0_00;
         default:      return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (i_reg_write && i_write_register == r) return i_write_data;
      return m_rf[r];
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
      e_valid = 0; e_pred = 0; e_ctrl = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_op = 0; e_fn = 0;
   endtask

   task automatic check_regs();
      chk("valid", o_valid, e_valid);
      chk("pred_taken", o_pred_taken, e_pred);
      chk("ctrl", {o_alu_src, o_reg_dst, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                   o_branch, o_alu_op}, e_ctrl);
      chk("rd1", o_read_data_1, e_rd1);
      chk("rd2", o_read_data_2, e_rd2);
      chk("imm", o_sign_extended_imm, e_imm);
      chk("fields", {o_rs, o_rt, o_rd, o_opcode, o_function}, {e_rs, e_rt, e_rd, e_op, e_fn});
   endtask

   task automatic idle();
      i_valid = 0; i_pc = 32'h0; i_next_pc = 32'h4; i_instruction = 32'h0;
      i_reg_write = 0; i_write_register = 0; i_write_data = 0;
      i_ex_mem_read = 0; i_ex_rt = 0; i_flush = 0;
      i_bht_update = 0; i_bht_pc = 0; i_bht_taken = 0;
   endtask

   // One clock: checks combinational outputs for the applied inputs, then the ID/EX register.
   task automatic step();
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic        is_br, rt_src, stall, pred, load;
      logic [31:0] tgt, sext;
      int          idx;
      #1;
      op     = i_instruction[31:26];
      rs     = i_instruction[25:21];
      rt     = i_instruction[20:16];
      is_br  = (op == 6'h04) || (op == 6'h05);
      rt_src = (op == 6'h00) || (op == 6'h2B) || is_br;
      stall  = i_valid && i_ex_mem_read && (i_ex_rt != 0) &&
               ((i_ex_rt == rs) || (rt_src && i_ex_rt == rt)) && !i_flush;
`ifdef ID_BHT_EN
      pred = m_bht[i_pc[5:2]][1];
`else
      pred = i_instruction[15];
`endif
      pred = pred && i_valid && is_br && !stall && !i_flush;
      sext = {{16{i_instruction[15]}}, i_instruction[15:0]};
      tgt  = i_next_pc + sext * 4;
      chk("stall", o_stall, stall);
      chk("prediction", o_branch_prediction, pred);
      chk("target", o_branch_target_addr, tgt);
      load = i_valid && !stall && !i_flush;
      if (load) begin
         e_valid = 1; e_pred = pred; e_ctrl = m_ctrl(op);
         e_rd1 = m_read(rs); e_rd2 = m_read(rt); e_imm = sext;
         e_rs = rs; e_rt = rt; e_rd = i_instruction[15:11]; e_op = op; e_fn = i_instruction[5:0];
      end else begin
         e_valid = 0; e_pred = 0; e_ctrl = 0;
      end
      @(posedge clk);
      #1;
      if (i_reg_write && i_write_register != 0) m_rf[i_write_register] = i_write_data;
`ifdef ID_BHT_EN
      if (i_bht_update) begin
         idx = int'(i_bht_pc[5:2]);
         if (i_bht_taken && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
         if (!i_bht_taken && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
      end
`else
      idx = 0;
`endif
      check_regs();
   endtask

   task automatic set_branch_at40(input logic [15:0] imm);
      idle();
      i_valid = 1; i_pc = 32'h40; i_next_pc = 32'h44;
      i_instruction = mk(6'h04, 5'd1, 5'd2, imm);
   endtask

   task automatic bht_upd(input logic taken);
      idle();
      i_bht_update = 1; i_bht_pc = 32'h40; i_bht_taken = taken;
      step();
   endtask

   initial begin
      idle();
      m_reset();
      // ---- reset state ----
      @(posedge clk); @(posedge clk); #1;
      check_regs();
      chk("rst_stall", o_stall, 0);
      reset = 0;

      // ---- mid-cycle reset clears the ID/EX register immediately ----
      idle(); i_valid = 1; i_instruction = mk(6'h00, 5'd5, 5'd6, {5'd3, 5'd0, 6'h20});
      step();
      chk("pre_rst_valid", o_valid, 1);
      #2 reset = 1;
      #1 m_reset();
      check_regs();
      chk("rst_reg_write", o_reg_write, 0);
      @(negedge clk); reset = 0;

      // ---- branch after reset predicts not-taken (counter 01 / forward branch) ----
      set_branch_at40(16'h0010);
      #1 chk("rst_branch_pred", o_branch_prediction, 0);
      step();

      // ---- load-use stall, then release ----
      idle(); i_valid = 1; i_ex_mem_read = 1; i_ex_rt = 5;
      i_instruction = mk(6'h00, 5'd5, 5'd6, {5'd3, 5'd0, 6'h20});
      #1 chk("lu_stall", o_stall, 1);
      step();
      chk("lu_bubble", o_valid, 0);
      i_ex_mem_read = 0;
      step();
      chk("lu_issue", o_valid, 1);
      chk("lu_rd", o_rd, 3);
      // load into $0 never stalls
      i_ex_mem_read = 1; i_ex_rt = 0; i_instruction = mk(6'h00, 5'd0, 5'd6, 16'h0020);
      #1 chk("lu_r0", o_stall, 0);
      step();

      // ---- write-through bypass and $0 ----
      idle(); i_valid = 1; i_reg_write = 1; i_write_register = 7; i_write_data = 32'hDEADBEEF;
      i_instruction = mk(6'h08, 5'd7, 5'd0, 16'h0001);
      step();
      chk("bypass", o_read_data_1, 32'hDEADBEEF);
      i_write_register = 0; i_write_data = 32'h1234; i_instruction = mk(6'h08, 5'd0, 5'd0, 16'h0);
      step();
      chk("r0_read", o_read_data_1, 0);
      i_reg_write = 0; i_instruction = mk(6'h00, 5'd0, 5'd7, 16'h0020);
      step();
      chk("r7_persist", o_read_data_2, 32'hDEADBEEF);

      // ---- prediction ----
`ifdef ID_BHT_EN
      bht_upd(1); bht_upd(1);
      set_branch_at40(16'hFFFF);
      #1 chk("bht_taken", o_branch_prediction, 1);
      chk("bht_target", o_branch_target_addr, 32'h40);
      step();
      chk("pred_taken_reg", o_pred_taken, 1);
      bht_upd(0); bht_upd(0); bht_upd(0);
      set_branch_at40(16'hFFFF);
      #1 chk("bht_not_taken", o_branch_prediction, 0);
      step();
      bht_upd(0);   // stays at 00
      bht_upd(1);   // 00 -> 01
      set_branch_at40(16'hFFFF);
      #1 chk("bht_floor", o_branch_prediction, 0);
      // same-cycle update taken (01 -> 10) and lookup: old counter used
      i_bht_update = 1; i_bht_pc = 32'h40; i_bht_taken = 1;
      #1 chk("same_idx_old", o_branch_prediction, 0);
      step();
      set_branch_at40(16'hFFFF);
      #1 chk("same_idx_new", o_branch_prediction, 1);
      step();
`else
      set_branch_at40(16'hFFFF);
      #1 chk("static_back", o_branch_prediction, 1);
      chk("static_target", o_branch_target_addr, 32'h40);
      step();
      chk("pred_taken_reg", o_pred_taken, 1);
      set_branch_at40(16'h0004);
      #1 chk("static_fwd", o_branch_prediction, 0);
      step();
      set_branch_at40(16'hFFFF); i_ex_mem_read = 1; i_ex_rt = 1;
      #1 chk("static_stalled", o_branch_prediction, 0);
      step();
`endif

      // ---- flush beats stall ----
      idle(); i_valid = 1; i_flush = 1; i_ex_mem_read = 1; i_ex_rt = 5;
      i_instruction = mk(6'h2B, 5'd5, 5'd2, 16'h0008);
      #1 chk("flush_stall", o_stall, 0);
      step();
      chk("flush_valid", o_valid, 0);
      chk("flush_mem_write", o_mem_write, 0);

      // ---- random traffic ----
      for (int n = 0; n < 600; n++) begin
         logic [5:0] op;
         int k;
         k = $urandom_range(0, 6);
         case (k)
            0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;
            3: op = 6'h04;  4: op = 6'h05;  5: op = 6'h08;
            default: op = 6'($urandom);
         endcase
         i_instruction    = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
         i_pc             = 32'h40 + 32'($urandom_range(0, 19)) * 4;
         i_next_pc        = i_pc + 4;
         i_valid          = ($urandom % 5) != 0;
         i_ex_mem_read    = ($urandom % 3) == 0;
         i_ex_rt          = 5'($urandom_range(0, 7));
         i_flush          = ($urandom % 10) == 0;
         i_reg_write      = $urandom % 2 == 1;
         i_write_register = 5'($urandom_range(0, 7));
         i_write_data     = $urandom;
         i_bht_update     = $urandom % 2 == 1;
         i_bht_pc         = 32'h40 + 32'($urandom_range(0, 19)) * 4;
         i_bht_taken      = $urandom % 2 == 1;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
